nonce_tx_arbiter: RTL

Shares the hub's single serial_transmit instance between SLAVES nonce sources (local miners and external slave ports). It latches each golden nonce into a per-slave pending slot and grants the transmitter round-robin. It drives the send/busy handshake and counts nonces lost to overwrite. It sits between the miners' nonce_out/is_golden outputs and serial_transmit's word/send/busy pins in fpgaminer_top.

---
 rtl/nonce_tx_arbiter_if.sv | 24 ++
 rtl/nonce_tx_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/nonce_tx_arbiter_if.sv
// Nonce-source and serial-transmitter handshake bundle for nonce_tx_arbiter.
// The master side is the hub (miners and serial_transmit); the slave side is the arbiter.
interface nonce_tx_arbiter_if #(
    parameter int SLAVES = 2,
    parameter int DROP_W = 16
);
    logic [SLAVES-1:0]    new_nonces;
    logic [SLAVES*32-1:0] slave_nonces;
    logic                 serial_busy;
    logic                 serial_send;
    logic [31:0]          golden_nonce;
    logic [SLAVES-1:0]    pending;
    logic [DROP_W-1:0]    drop_count;

    modport master (
        output new_nonces, slave_nonces, serial_busy,
        input  serial_send, golden_nonce, pending, drop_count
    );

    modport slave (
        input  new_nonces, slave_nonces, serial_busy,
        output serial_send, golden_nonce, pending, drop_count
    );
endinterface

// File: rtl/nonce_tx_arbiter.sv
// Round-robin sharing of one serial transmitter among SLAVES golden-nonce sources,
// with a per-source pending slot and a saturating count of overwritten nonces.
//   state     | meaning
//   IDLE      | waiting for a pending slot and an idle transmitter
//   SEND      | serial_send held until the transmitter reports busy
//   WAIT_DONE | frame in flight, waiting for busy to fall
module nonce_tx_arbiter #(
    parameter int SLAVES = 2,
    parameter int DROP_W = 16
) (
    input logic              hash_clk,
    input logic              reset,
    nonce_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SLAVES-1:0] pending_q, pending_d;
    logic [31:0]       slot_q [SLAVES];
    logic [31:0]       slot_d [SLAVES];
    logic              send_q, send_d;
    logic [31:0]       golden_q, golden_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    cand;
    logic [SLAVES-1:0] drop_mask;
    logic [5:0]        drop_inc;
    logic [DROP_W+5:0] drop_sum;

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= PTR_W'(SLAVES - 1);
            pending_q <= '0;
            send_q    <= 1'b0;
            golden_q  <= '0;
            drop_q    <= '0;
            for (int i = 0; i < SLAVES; i++) slot_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            send_q    <= send_d;
            golden_q  <= golden_d;
            drop_q    <= drop_d;
            for (int i = 0; i < SLAVES; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Scan starts one past the last winner so every source gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == IDLE && !bus.serial_busy) begin
            for (int k = 1; k <= SLAVES; k++) begin
                cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(SLAVES)) cand = cand - (PTR_W+1)'(SLAVES);
                if (!grant_vld && pending_q[cand[PTR_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[PTR_W-1:0];
                end
            end
        end
    end

    // A nonce arriving on the slot being granted is kept, not counted as a drop.
    always_comb begin
        pending_d = pending_q;
        drop_mask = '0;
        drop_inc  = '0;
        for (int i = 0; i < SLAVES; i++) begin
            slot_d[i] = slot_q[i];
            if (grant_vld && grant_idx == PTR_W'(i)) pending_d[i] = 1'b0;
            if (bus.new_nonces[i]) begin
                slot_d[i]    = bus.slave_nonces[i*32 +: 32];
                pending_d[i] = 1'b1;
                drop_mask[i] = pending_q[i] && !(grant_vld && grant_idx == PTR_W'(i));
            end
        end
        for (int i = 0; i < SLAVES; i++) drop_inc = drop_inc + 6'(drop_mask[i]);
        drop_sum = (DROP_W+6)'(drop_q) + (DROP_W+6)'(drop_inc);
        drop_d   = (drop_sum > (DROP_W+6)'({DROP_W{1'b1}})) ? {DROP_W{1'b1}}
                                                          : drop_sum[DROP_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (grant_vld)         state_d = SEND;
            SEND:      if (bus.serial_busy)   state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.serial_busy)  state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        send_d   = 1'b0;
        golden_d = golden_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: if (grant_vld) begin
                send_d   = 1'b1;
                golden_d = slot_q[grant_idx];
                rr_ptr_d = grant_idx;
            end
            SEND:    send_d = !bus.serial_busy;
            default: send_d = 1'b0;
        endcase
    end

    assign bus.serial_send  = send_q;
    assign bus.golden_nonce = golden_q;
    assign bus.pending      = pending_q;
    assign bus.drop_count   = drop_q;
endmodule
